pipe_stage_reg: RTL and testbench

- Parametrised, generalised successor to the fixed decode→execute pipeline register.
- Carries a control bundle, a data bundle and a valid bit through STAGES register slices.
- Adds stall (hold), flush (bubble insert), valid-gated control zeroing, and saturating stall/bubble performance counters.
- Instantiated between any two core pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), replacing per-stage hand-written registers.

---
 rtl/pipe_pkg.sv | 33 +++
 rtl/pipe_stage_slice.sv | 44 ++++
 rtl/pipe_stage_reg.sv | 95 +++++++++
 tb/tb_pipe_stage_reg.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline typedefs: ID/EX control and data bundles and their widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Ports: none. Widths are derived from the structs so a field change propagates.
package pipe_pkg;

   // ID/EX control bundle, MSB first.
   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
      logic       mem_write;
      logic       jump;
      logic [1:0] branch;
      logic [2:0] alu_control;
      logic       alu_src;
      logic [1:0] imm_src;
   } id_ex_ctrl_t;

   // ID/EX data bundle, MSB first.
   typedef struct packed {
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] pc;
      logic [31:0] imm_ext;
      logic [31:0] pc_plus4;
      logic [4:0]  rd;
   } id_ex_data_t;

   localparam int ID_EX_CTRL_W = $bits(id_ex_ctrl_t);
   localparam int ID_EX_DATA_W = $bits(id_ex_data_t);

endpackage

// File: rtl/pipe_stage_slice.sv
// One pipeline register slice: valid + control + data.
// Latency: 1 cycle.
// Backpressure: stall holds the slice; flush drops valid/ctrl but keeps data.
//
// Ports: clk/rst (sync, active-high); flush, stall (shared with all slices);
// src_valid/src_ctrl/src_data from the previous slice or upstream stage;
// valid/ctrl/data are the registered slice contents.
module pipe_stage_slice
   import pipe_pkg::*;
#(
   parameter int CTRL_W = ID_EX_CTRL_W,
   parameter int DATA_W = ID_EX_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              stall,
   input  logic              src_valid,
   input  logic [CTRL_W-1:0] src_ctrl,
   input  logic [DATA_W-1:0] src_data,
   output logic              valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] data
);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         ctrl  <= '0;
         data  <= '0;
      end else if (flush) begin
         // Bubble: kill the entry and its side effects; data is don't-care
         // once valid is low, so it is left alone to save toggles.
         valid <= 1'b0;
         ctrl  <= '0;
      end else if (!stall) begin
         valid <= src_valid;
         // An invalid entry must never carry live control downstream.
         ctrl  <= src_valid ? src_ctrl : '0;
         data  <= src_data;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: STAGES slices plus stall/bubble counters.
// Latency: STAGES cycles when neither stalled nor flushed; one entry per cycle.
// Backpressure: stall freezes every slice together; flush bubbles every slice (wins over stall).
//
// Ports: clk, rst (sync, active-high); stall, flush, cnt_clr controls;
// valid_d/ctrl_d/data_d upstream entry; valid_e/ctrl_e/data_e last-slice registers;
// stall_cnt counts effective stall cycles, bubble_cnt counts cycles with valid_e low,
// both saturating at all-ones.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int CTRL_W = ID_EX_CTRL_W,
   parameter int DATA_W = ID_EX_DATA_W,
   parameter int STAGES = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              cnt_clr,
   input  logic              valid_d,
   input  logic [CTRL_W-1:0] ctrl_d,
   input  logic [DATA_W-1:0] data_d,
   output logic              valid_e,
   output logic [CTRL_W-1:0] ctrl_e,
   output logic [DATA_W-1:0] data_e,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   if (STAGES < 1) begin : g_bad_stages
      $error("pipe_stage_reg: STAGES must be >= 1");
   end

   logic              slc_valid [STAGES];
   logic [CTRL_W-1:0] slc_ctrl  [STAGES];
   logic [DATA_W-1:0] slc_data  [STAGES];

   for (genvar k = 0; k < STAGES; k++) begin : g_slice
      logic              src_valid;
      logic [CTRL_W-1:0] src_ctrl;
      logic [DATA_W-1:0] src_data;

      if (k == 0) begin : g_head
         assign src_valid = valid_d;
         assign src_ctrl  = ctrl_d;
         assign src_data  = data_d;
      end else begin : g_chain
         assign src_valid = slc_valid[k-1];
         assign src_ctrl  = slc_ctrl[k-1];
         assign src_data  = slc_data[k-1];
      end

      pipe_stage_slice #(
         .CTRL_W (CTRL_W),
         .DATA_W (DATA_W)
      ) u_slice (
         .clk       (clk),
         .rst       (rst),
         .flush     (flush),
         .stall     (stall),
         .src_valid (src_valid),
         .src_ctrl  (src_ctrl),
         .src_data  (src_data),
         .valid     (slc_valid[k]),
         .ctrl      (slc_ctrl[k]),
         .data      (slc_data[k])
      );
   end

   // Outputs are straight from the last slice's flops.
   assign valid_e = slc_valid[STAGES-1];
   assign ctrl_e  = slc_ctrl[STAGES-1];
   assign data_e  = slc_data[STAGES-1];

   // A stall that coincides with a flush is not counted: the flush moved the pipe.
   // bubble_cnt looks at the pre-edge valid_e, so the first cycle out of reset counts.
   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (stall && !flush && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         if (!valid_e && (bubble_cnt != CNT_MAX)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a 1-slice/16-bit-counter instance and a 3-slice/4-bit-counter
// instance share stimulus and are checked every cycle against a queue-based model,
// plus directed checks for the notable scenarios.
module tb_pipe_stage_reg;
   import pipe_pkg::*;

   localparam int CW = ID_EX_CTRL_W;
   localparam int DW = ID_EX_DATA_W;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, stall, flush, cnt_clr, valid_d;
   logic [CW-1:0] ctrl_d;
   logic [DW-1:0] data_d;

   logic          v1, v3;
   logic [CW-1:0] c1, c3;
   logic [DW-1:0] d1, d3;
   logic [15:0]   sc1, bc1;
   logic [3:0]    sc3, bc3;

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .STAGES(1), .CNT_W(16)) dut1 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
      .valid_d(valid_d), .ctrl_d(ctrl_d), .data_d(data_d),
      .valid_e(v1), .ctrl_e(c1), .data_e(d1), .stall_cnt(sc1), .bubble_cnt(bc1));

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .STAGES(3), .CNT_W(4)) dut3 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
      .valid_d(valid_d), .ctrl_d(ctrl_d), .data_d(data_d),
      .valid_e(v3), .ctrl_e(c3), .data_e(d3), .stall_cnt(sc3), .bubble_cnt(bc3));

   // ---------------- reference model ----------------
   typedef struct {
      bit            v;
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } ent_t;

   ent_t pipe [2][$];
   int   m_sc [2];
   int   m_bc [2];
   int   depth [2] = '{1, 3};
   int   cmax  [2] = '{65535, 15};

   int checks = 0;
   int errors = 0;

   task automatic model_reset(input int m);
      ent_t z;
      z.v = 1'b0; z.c = '0; z.d = '0;
      pipe[m].delete();
      for (int i = 0; i < depth[m]; i++) pipe[m].push_back(z);
      m_sc[m] = 0;
      m_bc[m] = 0;
   endtask

   // Applies one rising edge's worth of the rules to both models.
   task automatic model_edge();
      ent_t e;
      bit   pre_v;
      for (int m = 0; m < 2; m++) begin
         if (rst) begin
            model_reset(m);
         end else begin
            pre_v = pipe[m][$].v;
            if (cnt_clr) begin
               m_sc[m] = 0;
               m_bc[m] = 0;
            end else begin
               if (stall && !flush) m_sc[m] = (m_sc[m] < cmax[m]) ? m_sc[m] + 1 : m_sc[m];
               if (!pre_v)          m_bc[m] = (m_bc[m] < cmax[m]) ? m_bc[m] + 1 : m_bc[m];
            end
            if (flush) begin
               foreach (pipe[m][i]) begin
                  pipe[m][i].v = 1'b0;
                  pipe[m][i].c = '0;
               end
            end else if (!stall) begin
               e.v = valid_d;
               e.c = valid_d ? ctrl_d : '0;
               e.d = data_d;
               pipe[m].push_front(e);
               void'(pipe[m].pop_back());
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      chk("s1_valid", DW'(v1), DW'(pipe[0][$].v));
      chk("s1_ctrl",  DW'(c1), DW'(pipe[0][$].c));
      chk("s1_data",  d1,      pipe[0][$].d);
      chk("s1_stall_cnt",  DW'(sc1), DW'(m_sc[0]));
      chk("s1_bubble_cnt", DW'(bc1), DW'(m_bc[0]));
      chk("s3_valid", DW'(v3), DW'(pipe[1][$].v));
      chk("s3_ctrl",  DW'(c3), DW'(pipe[1][$].c));
      chk("s3_data",  d3,      pipe[1][$].d);
      chk("s3_stall_cnt",  DW'(sc3), DW'(m_sc[1]));
      chk("s3_bubble_cnt", DW'(bc3), DW'(m_bc[1]));
   endtask

   // One clock: model follows the edge, DUTs are sampled 1ns later.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   function automatic logic [DW-1:0] rnd_data();
      logic [191:0] w;
      w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return w[DW-1:0];
   endfunction

   id_ex_data_t pat;
   logic [DW-1:0] xdat;
   logic [CW-1:0] seen [$];

   initial begin
      model_reset(0);
      model_reset(1);

      // Reset with every other input high.
      rst = 1; stall = 1; flush = 1; cnt_clr = 1; valid_d = 1;
      ctrl_d = '1; data_d = '1;
      #1;
      step();
      step();
      chk("rst_valid_e", DW'(v1), '0);
      chk("rst_ctrl_e",  DW'(c1), '0);
      chk("rst_data_e",  d1,      '0);
      chk("rst_cnts",    DW'({sc1, bc1}), '0);

      // Basic load.
      pat = '0;
      pat.pc = 32'h100; pat.pc_plus4 = 32'h104; pat.rd1 = 32'hA5A5_0001;
      pat.rd2 = 32'h5A5A_0002; pat.imm_ext = 32'h10; pat.rd = 5'd7;
      rst = 0; stall = 0; flush = 0; cnt_clr = 0;
      valid_d = 1; ctrl_d = 13'h0A5; data_d = pat;
      step();
      chk("load_valid_e", DW'(v1), DW'(1'b1));
      chk("load_ctrl_e",  DW'(c1), DW'(13'h0A5));
      chk("load_data_e",  d1,      DW'(pat));

      // Stall hold.
      ctrl_d = 13'h1; cnt_clr = 1;
      step();
      cnt_clr = 0; stall = 1; ctrl_d = 13'h2;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_hold_ctrl", DW'(c1), DW'(13'h1));
      end
      chk("stall_cnt_3", DW'(sc1), DW'(3));
      stall = 0;
      step();
      chk("stall_release_ctrl", DW'(c1), DW'(13'h2));

      // Flush wins over stall; data stays.
      xdat = rnd_data();
      ctrl_d = 13'h1F; data_d = xdat;
      step();
      chk("pre_flush_ctrl", DW'(c1), DW'(13'h1F));
      flush = 1; stall = 1; data_d = rnd_data();
      step();
      chk("flush_valid_e", DW'(v1), '0);
      chk("flush_ctrl_e",  DW'(c1), '0);
      chk("flush_data_e",  d1,      xdat);
      chk("flush_no_stall_cnt", DW'(sc1), DW'(3));

      // Invalid entry carries no control but does carry data.
      flush = 0; stall = 0; valid_d = 0; ctrl_d = 13'h1FFF; xdat = rnd_data(); data_d = xdat;
      step();
      chk("inv_valid_e", DW'(v1), '0);
      chk("inv_ctrl_e",  DW'(c1), '0);
      chk("inv_data_e",  d1,      xdat);
      step();

      // Multi-stage stream 1,2,(stall),3,4 through the 3-slice instance.
      flush = 1;
      step();
      flush = 0; valid_d = 1;
      for (int i = 0; i < 5; i++) begin
         stall = (i == 2);
         ctrl_d = (i < 2) ? CW'(i + 1) : CW'(i);
         data_d = rnd_data();
         step();
         if (v3) seen.push_back(c3);
      end
      stall = 0; valid_d = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (v3) seen.push_back(c3);
      end
      chk("stream_len", DW'(seen.size()), DW'(4));
      for (int i = 0; i < seen.size() && i < 4; i++) chk("stream_order", DW'(seen[i]), DW'(i + 1));

      // Fill the 3 slices, flush, keep streaming: exactly 3 empty outputs follow.
      valid_d = 1;
      for (int i = 0; i < 3; i++) begin
         ctrl_d = CW'(i + 8);
         step();
      end
      flush = 1;
      step();
      chk("mflush_valid_0", DW'(v3), '0);
      flush = 0;
      step();
      chk("mflush_valid_1", DW'(v3), '0);
      step();
      chk("mflush_valid_2", DW'(v3), '0);
      step();
      chk("mflush_refill", DW'(v3), DW'(1'b1));

      // Saturation of the 4-bit counter, then clear beating increment.
      cnt_clr = 1;
      step();
      cnt_clr = 0; stall = 1;
      for (int i = 0; i < 20; i++) step();
      chk("sat_stall_cnt", DW'(sc3), DW'(15));
      chk("nosat_stall_cnt", DW'(sc1), DW'(20));
      cnt_clr = 1;
      step();
      chk("clr_stall_cnt", DW'(sc3), '0);
      chk("clr_bubble_cnt", DW'(bc3), '0);
      cnt_clr = 0; stall = 0;

      // Random traffic, including mid-stream reset.
      for (int i = 0; i < 600; i++) begin
         rst     = ($urandom_range(0, 99) < 2);
         flush   = ($urandom_range(0, 99) < 8);
         stall   = ($urandom_range(0, 99) < 25);
         cnt_clr = ($urandom_range(0, 99) < 2);
         valid_d = ($urandom_range(0, 99) < 70);
         ctrl_d  = CW'($urandom());
         data_d  = rnd_data();
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
